// File: rtl/crc_pkg.sv
// Shared constants and types for the byte-serial CRC-32 framer.
// Imported by the divide step and the framer top.
package crc_pkg;

  localparam int CRC_W  = 32;
  localparam int BYTE_W = 8;

  localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } framer_state_t;

endpackage

// File: rtl/crc_div_bit.sv
// One-bit-per-clock CRC divide step with a registered remainder.
// The x^32 term of the generator is implicit.
module crc_div_bit
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLYNOMIAL = CRC32_POLY
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_bit,
  input  logic             i_bit_en,
  output logic [CRC_W-1:0] o_state
);

  logic [CRC_W-1:0] nxt;

  // shift in one bit, reduce by the generator when x^31 falls out
  always_comb begin
    nxt = {o_state[CRC_W-2:0], i_bit};
    if (o_state[CRC_W-1]) begin
      nxt = nxt ^ POLYNOMIAL;
    end
  end

  // remainder register; clear wins over a shift
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_state <= '0;
    end else if (i_clear) begin
      o_state <= '0;
    end else if (i_bit_en) begin
      o_state <= nxt;
    end
  end

endmodule

// File: rtl/crc32_byte_framer.sv
// Byte stream to bit-serial CRC-32 framer: serializes bytes,
// appends 32 zero bits, and publishes the remainder with a strobe.
module crc32_byte_framer
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLYNOMIAL = CRC32_POLY,
  parameter logic             LSB_FIRST  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_busy,
  output logic [CRC_W-1:0]  o_crc,
  output logic              o_crc_valid
);

  framer_state_t     state;
  logic [2:0]        bit_cnt;
  logic [4:0]        flush_cnt;
  logic [BYTE_W-1:0] byte_q;
  logic              last_q;
  logic              mid_frame;

  logic              hs;
  logic [2:0]        bit_idx;
  logic              div_clear;
  logic              div_bit;
  logic              div_en;
  logic [CRC_W-1:0]  crc;

  // handshake window and bit selection for the divide step
  always_comb begin
    o_ready   = 1'b0;
    div_bit   = 1'b0;
    div_en    = 1'b0;
    bit_idx   = LSB_FIRST ? bit_cnt : 3'd7 - bit_cnt;
    unique case (state)
      IDLE: o_ready = 1'b1;
      SHIFT: begin
        o_ready = (bit_cnt == 3'd7) && !last_q;
        div_bit = byte_q[bit_idx];
        div_en  = 1'b1;
      end
      FLUSH: div_en = 1'b1;
      DONE: o_ready = 1'b0;
      default: o_ready = 1'b0;
    endcase
    hs        = i_valid && o_ready;
    div_clear = hs && (state == IDLE) && !mid_frame;
  end

  assign o_busy = (state != IDLE);

  crc_div_bit #(
    .POLYNOMIAL(POLYNOMIAL)
  ) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (div_clear),
    .i_bit   (div_bit),
    .i_bit_en(div_en),
    .o_state (crc)
  );

  // frame sequencing: byte capture, shift, flush, publish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      flush_cnt   <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      mid_frame   <= 1'b0;
      o_crc       <= '0;
      o_crc_valid <= 1'b0;
    end else begin
      o_crc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            byte_q  <= i_data;
            last_q  <= i_last;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (last_q) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end else if (hs) begin
              byte_q  <= i_data;
              last_q  <= i_last;
              bit_cnt <= '0;
            end else begin
              mid_frame <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 5'd1;
          if (flush_cnt == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          o_crc       <= crc;
          o_crc_valid <= 1'b1;
          mid_frame   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_byte_framer.sv
// Bench for crc32_byte_framer: vector table, hand sequences and
// random frames against a direct-form CRC reference.
module tb_crc32_byte_framer;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        rdy_m, busy_m, cv_m;
  logic        rdy_l, busy_l, cv_l;
  logic [31:0] crc_m, crc_l;

  int ncmp;
  int nfail;
  int cyc;

  crc32_byte_framer #(.POLYNOMIAL(POLY), .LSB_FIRST(1'b0)) dut_m (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(rdy_m), .o_busy(busy_m),
    .o_crc(crc_m), .o_crc_valid(cv_m)
  );

  crc32_byte_framer #(.POLYNOMIAL(POLY), .LSB_FIRST(1'b1)) dut_l (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(rdy_l), .o_busy(busy_l),
    .o_crc(crc_l), .o_crc_valid(cv_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          len;
    logic [71:0] data;
    int          gap;
    bit          m_known;
    logic [31:0] em;
    bit          l_known;
    logic [31:0] el;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // direct-form CRC (no augmentation), init 0, no final xor
  function automatic logic [31:0] ref_crc(input logic [7:0] d[$],
                                          input bit lsb);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'h0;
    foreach (d[i]) begin
      b = lsb ? rev8(d[i]) : d[i];
      c = c ^ {b, 24'h0};
      for (int k = 0; k < 8; k++)
        c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  task automatic junk_drive();
    i_valid = 1'($urandom_range(1));
    i_data  = 8'($urandom);
    i_last  = 1'($urandom_range(1));
  endtask

  task automatic run_frame(input string name, input logic [7:0] d[$],
                           input int gap, input logic [31:0] em,
                           input logic [31:0] el);
    int idx, first_hs, prev_hs, bad_gap, guard;
    int strobes, st_cyc, consec;
    logic prev_v;
    logic [31:0] got_m, got_l;
    idx = 0; first_hs = -1; prev_hs = -1; bad_gap = 0; guard = 0;
    while (idx < d.size() && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      if (!rdy_m) begin
        junk_drive();
      end else begin
        i_valid = ($urandom_range(99) >= gap);
        i_data  = d[idx];
        i_last  = (idx == d.size() - 1);
      end
      @(negedge clk);
      if (i_valid && rdy_m) begin
        if (first_hs < 0) first_hs = cyc + 1;
        if (prev_hs >= 0 && (cyc + 1 - prev_hs) != 8) bad_gap++;
        prev_hs = cyc + 1;
        idx++;
      end
    end
    chk({name, " bytes_accepted"}, idx, d.size());
    @(posedge clk); #1;
    junk_drive();
    strobes = 0; st_cyc = -1; consec = 0; prev_v = 1'b0;
    got_m = '0; got_l = '0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (cv_m && prev_v) consec++;
      prev_v = cv_m;
      if (cv_m) begin
        strobes++;
        if (st_cyc < 0) begin
          st_cyc = cyc;
          got_m  = crc_m;
          got_l  = crc_l;
        end
      end
      if (st_cyc < 0) junk_drive();
      else i_valid = 1'b0;
    end
    chk({name, " crc_msb"}, got_m, em);
    chk({name, " crc_lsb"}, got_l, el);
    chk({name, " strobes"}, strobes, 1);
    chk({name, " consecutive"}, consec, 0);
    chk({name, " latency"}, st_cyc - prev_hs, 41);
    chk({name, " crc_hold"}, crc_m, em);
    chk({name, " busy_after"}, {31'h0, busy_m}, 32'h0);
    if (gap == 0) begin
      chk({name, " span"}, st_cyc - first_hs, 8 * (d.size() - 1) + 41);
      chk({name, " ready_period"}, bad_gap, 0);
    end
  endtask

  vec_t tbl [6];

  initial begin
    logic [7:0] q[$];
    logic [31:0] em, el;
    int strobes;
    ncmp = 0;
    nfail = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;

    tbl[0] = '{1, {8'h00, 64'h0}, 0, 1'b1, 32'h0, 1'b1, 32'h0};
    tbl[1] = '{1, {8'h01, 64'h0}, 0, 1'b1, 32'h04C11DB7, 1'b0, 32'h0};
    tbl[2] = '{2, {16'h0001, 56'h0}, 0, 1'b1, 32'h04C11DB7, 1'b0, 32'h0};
    tbl[3] = '{9, 72'h313233343536373839, 0, 1'b1, 32'h89A1897F,
               1'b0, 32'h0};
    tbl[4] = '{9, 72'h313233343536373839, 40, 1'b1, 32'h89A1897F,
               1'b0, 32'h0};
    tbl[5] = '{1, {8'h80, 64'h0}, 0, 1'b0, 32'h0, 1'b1, 32'h04C11DB7};

    // reset state
    repeat (3) @(posedge clk);
    i_valid = 1'b1; i_data = 8'hA5; i_last = 1'b1;
    @(negedge clk);
    chk("rst crc", crc_m, 32'h0);
    chk("rst crc_valid", {31'h0, cv_m}, 32'h0);
    chk("rst busy", {31'h0, busy_m}, 32'h0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", {31'h0, rdy_m}, 32'h1);
    chk("post_rst busy", {31'h0, busy_m}, 32'h0);

    // table vectors
    for (int t = 0; t < 6; t++) begin
      q = {};
      for (int i = 0; i < tbl[t].len; i++)
        q.push_back(tbl[t].data[71 - 8 * i -: 8]);
      em = tbl[t].m_known ? tbl[t].em : ref_crc(q, 1'b0);
      el = tbl[t].l_known ? tbl[t].el : ref_crc(q, 1'b1);
      run_frame($sformatf("vec%0d", t), q, tbl[t].gap, em, el);
    end

    // reset in the middle of the flush aborts the frame
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 8'h01; i_last = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cv_m) strobes++;
    end
    chk("abort strobes", strobes, 0);
    chk("abort crc", crc_m, 32'h0);
    chk("abort busy", {31'h0, busy_m}, 32'h0);
    chk("abort ready", {31'h0, rdy_m}, 32'h1);
    q = {8'h01};
    run_frame("after_abort", q, 0, 32'h04C11DB7, ref_crc(q, 1'b1));

    // random frames
    for (int r = 0; r < 10; r++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++)
        q.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", r), q,
                ($urandom_range(1) != 0) ? 35 : 0,
                ref_crc(q, 1'b0), ref_crc(q, 1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/crc32_byte_framer.md
Name: crc32_byte_framer

Overview:
- Upstream feeder and finisher for the team's bit-serial CRC-32 divider.
- Accepts a byte stream with valid/ready/last handshake and serializes each byte into a 1-bit CRC divide step, one bit per clock.
- After the last byte, appends 32 zero bits so the remainder equals M(x)·x^32 mod P.
- Publishes the 32-bit CRC with a one-cycle valid strobe. It sits between packet byte sources (UART/Ethernet RX paths) and frame-check logic.

Parameters:
- POLYNOMIAL, 32'h04C11DB7, generator polynomial; implicit x^32 term.
- LSB_FIRST, 1'b0, 0 = serialize bit 7 first, 1 = bit 0 first.

Ports:
- i_clk  input  1  clock; all logic on posedge.
- i_rst  input  1  reset; synchronous, active-high.
- i_data  input  8  byte to process.
- i_valid  input  1  i_data/i_last valid.
- i_last  input  1  final byte of frame; qualified by i_valid.
- o_ready  output  1  byte accepted on cycles where i_valid && o_ready.
- o_busy  output  1  high in any state other than IDLE.
- o_crc  output  32  remainder of the most recent frame; holds until the next result.
- o_crc_valid  output  1  one-cycle strobe when o_crc updates.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (i_clk, i_rst). Reset forces state IDLE, the CRC register and bit counter to 0, o_crc=0, o_crc_valid=0, o_busy=0. Inputs are ignored while i_rst=1. o_ready=1 in the first cycle after i_rst deasserts.
- FSM states: IDLE, SHIFT, FLUSH, DONE.
- IDLE:
  - o_ready=1.
  - On handshake: CRC register cleared to 0 (same edge), byte and last flag latched, bit_cnt=0, go to SHIFT.
- SHIFT:
  - Each cycle shifts one bit of the latched byte into the divide step; order set by LSB_FIRST. bit_cnt increments.
  - o_ready=1 only when bit_cnt==7 and the latched last flag is 0. This gives back-to-back bytes at 8 clocks/byte with no bubble.
  - At bit_cnt==7 with handshake: load the new byte, bit_cnt=0, stay in SHIFT.
  - At bit_cnt==7 without handshake: go to IDLE-wait. The CRC register is NOT cleared, because the frame is still open. Implement this as a sub-flag "mid_frame"; the next IDLE handshake clears the CRC only if mid_frame=0.
  - At bit_cnt==7 with latched last=1: go to FLUSH with flush_cnt=0.
- FLUSH:
  - Shifts a 0 bit every cycle for 32 cycles (flush_cnt 0..31). o_ready=0.
  - After the 32nd shift, go to DONE.
- DONE:
  - o_crc <= CRC register, o_crc_valid=1 for exactly this one cycle, o_ready=0. Then go to IDLE and clear mid_frame.
- Divide step (each shift): next = {crc[30:0], bit} ^ (crc[31] ? POLYNOMIAL : 0).
- Latency: last byte accepted at edge E0 → data shifts at E1..E8 → flush E9..E40 → o_crc_valid high in the cycle after E41. The strobe is 41 cycles after the last handshake cycle.
- Boundary cases:
  - i_valid with i_data changing while o_ready=0: ignored; no capture.
  - Single-byte frame (first byte also last): legal.
  - Frames of zero bytes are impossible; no CRC is produced without a byte.
  - i_rst asserted mid-SHIFT or mid-FLUSH: frame is aborted, no o_crc_valid, o_crc returns to 0.
  - o_crc_valid never asserts on two consecutive cycles.

Decomposition:
- Package crc_pkg:
  - CRC32_POLY constant (32'h04C11DB7).
  - CRC_W=32, BYTE_W=8.
  - framer_state_t enum {IDLE, SHIFT, FLUSH, DONE}.
- One sub-module, crc_div_bit: registered 32-bit divide step with inputs clear, bit, bit_en and output state.
  - Parameterized by POLYNOMIAL, synchronous active-high reset.
  - The framer instantiates it once and drives clear/bit/bit_en from the FSM.

Test Plan:
- Single byte 0x00, last=1 → o_crc=32'h00000000, strobe 41 cycles after handshake.
- Single byte 0x01, MSB-first → o_crc=32'h04C11DB7. Bytes 0x00,0x01 → same 32'h04C11DB7, since leading zeros have no effect.
- ASCII "123456789" back-to-back, i_valid held high, MSB-first → o_crc=32'h89A1897F.
  - Also check: o_ready pulses every 8 cycles, total handshake-to-strobe span is 8×8+41 cycles.
- Same frame with random i_valid gaps (mid_frame idle periods) → identical 32'h89A1897F; o_crc_valid exactly once.
- LSB_FIRST=1, single byte 0x80 → o_crc=32'h04C11DB7 (bit 7 shifted last).
- Reset check:
  - Assert i_rst for 1 cycle during FLUSH of a frame → no strobe, o_crc=0.
  - Next frame {0x01} → 32'h04C11DB7, proving the CRC register cleared.
